// File: rtl/clock_div_gen_if.sv
// -----------------------------------------------------------------------------
// clock_div_gen_if
// Purpose : bundles the configuration, enable/gate and clock/status signals of
//           the multi-channel programmable clock generator.
// Params  : NUM_CH  - number of output clock channels (1..16)
//           DIV_W   - width of the half-period count
//           PHASE_W - width of the start phase offset
// Signals : cfg_wr/cfg_ch/cfg_half_div/cfg_phase - config write (master -> slave)
//           cfg_err                               - rejected write pulse
//           ch_en/gate_en                         - per-channel run enable / gate
//           ch_clk/ch_active                      - divided clocks / channel busy
//           evt_cfg_done/evt_gate                 - optional event pulses
// Modports: master (drives config/enables), slave (the generator).
// -----------------------------------------------------------------------------
interface clock_div_gen_if #(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = 8,
    parameter int PHASE_W = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                cfg_wr;
    logic [CH_W-1:0]     cfg_ch;
    logic [DIV_W-1:0]    cfg_half_div;
    logic [PHASE_W-1:0]  cfg_phase;
    logic                cfg_err;
    logic [NUM_CH-1:0]   ch_en;
    logic [NUM_CH-1:0]   gate_en;
    logic [NUM_CH-1:0]   ch_clk;
    logic [NUM_CH-1:0]   ch_active;
    logic [NUM_CH-1:0]   evt_cfg_done;
    logic [NUM_CH-1:0]   evt_gate;

    modport master (
        output cfg_wr, cfg_ch, cfg_half_div, cfg_phase, ch_en, gate_en,
        input  cfg_err, ch_clk, ch_active, evt_cfg_done, evt_gate
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_half_div, cfg_phase, ch_en, gate_en,
        output cfg_err, ch_clk, ch_active, evt_cfg_done, evt_gate
    );
endinterface

// File: rtl/clock_div_gen.sv
// -----------------------------------------------------------------------------
// clock_div_gen
// Purpose : derives NUM_CH divided clocks from CLOCK. Each channel has a
//           programmable half period, a start phase offset and a glitch-free
//           gate. Divide-ratio changes are applied only at the raw 1->0 period
//           boundary so no pulse is ever truncated.
// Ports   : CLOCK - source clock (rising edge)
//           RESET - asynchronous, active-high reset
//           bus   - clock_div_gen_if.slave (config, enables, clocks, events)
// Option  : CLOCK_DIV_GEN_EVT_EN - builds evt_cfg_done / evt_gate pulses;
//           when undefined those outputs are tied low.
// -----------------------------------------------------------------------------
module clock_div_gen #(
    parameter int NUM_CH  = 4,
    parameter int DIV_W   = 8,
    parameter int PHASE_W = 8
) (
    input  logic           CLOCK,
    input  logic           RESET,
    clock_div_gen_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (DIV_W > PHASE_W) ? DIV_W : PHASE_W;
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    logic              w_wr_ok;
    logic              w_wr_bad;
    logic              r_cfg_err;
    logic [NUM_CH-1:0] w_clk_v;
    logic [NUM_CH-1:0] w_active_v;
    logic [NUM_CH-1:0] w_evt_cfg_v;
    logic [NUM_CH-1:0] w_evt_gate_v;

    // Config write legality: non-zero half period and an existing channel.
    always_comb begin
        w_wr_ok  = bus.cfg_wr & ({1'b0, bus.cfg_ch} < NUM_CH_L)
                 & (bus.cfg_half_div != {DIV_W{1'b0}});
        w_wr_bad = bus.cfg_wr & ~w_wr_ok;
    end

    // Rejected-write pulse, one cycle after the offending strobe.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) r_cfg_err <= 1'b0;
        else       r_cfg_err <= w_wr_bad;
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t             r_state, w_state_nxt;
        logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_half_m1, w_phase_m1;
        logic               r_raw, w_raw_nxt, w_copy, w_sel;
        logic               r_gate_q, w_gate_nxt, w_gate_ld;
        logic               r_clk, r_active, w_active_nxt;
        logic [DIV_W-1:0]   r_sh_half, r_act_half;
        logic [PHASE_W-1:0] r_sh_phase, r_act_phase;

        // Channel select and terminal counts derived from the active config.
        always_comb begin
            w_sel      = w_wr_ok & (bus.cfg_ch == CH_W'(gi));
            w_half_m1  = CNT_W'(r_act_half) - CNT_W'(1'b1);
            w_phase_m1 = CNT_W'(r_act_phase) - CNT_W'(1'b1);
        end

        // FSM state register with divider counter and raw divided clock.
        always_ff @(posedge CLOCK or posedge RESET) begin
            if (RESET) begin
                r_state <= ST_IDLE;
                r_cnt   <= {CNT_W{1'b0}};
                r_raw   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_raw   <= w_raw_nxt;
            end
        end

        // FSM next state; w_copy marks every shadow->active transfer.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_raw_nxt   = r_raw;
            w_copy      = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = {CNT_W{1'b0}};
                    w_raw_nxt = 1'b0;
                    if (bus.ch_en[gi]) begin
                        w_copy = 1'b1;
                        // A zero phase starts the high half immediately.
                        if (r_sh_phase == {PHASE_W{1'b0}}) begin
                            w_state_nxt = ST_RUN;
                            w_raw_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_PHASE;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_PHASE: begin
                    if (!bus.ch_en[gi]) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end else if (r_cnt == w_phase_m1) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                        w_raw_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1'b1);
                    end
                end
                ST_RUN: begin
                    if (!bus.ch_en[gi] && !r_raw) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                    end else if (r_cnt == w_half_m1) begin
                        w_cnt_nxt = {CNT_W{1'b0}};
                        w_raw_nxt = ~r_raw;
                        // Falling raw edge is the period boundary.
                        if (r_raw) begin
                            w_copy      = 1'b1;
                            w_state_nxt = bus.ch_en[gi] ? ST_RUN : ST_IDLE;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1'b1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_raw_nxt   = 1'b0;
                end
            endcase
        end

        // Outputs: gate only moves while raw is low now and next cycle.
        always_comb begin
            w_gate_ld    = ~r_raw & ~w_raw_nxt;
            w_gate_nxt   = w_gate_ld ? bus.gate_en[gi] : r_gate_q;
            w_active_nxt = (w_state_nxt != ST_IDLE);
        end

        // Registered gate, gated clock and active flag.
        always_ff @(posedge CLOCK or posedge RESET) begin
            if (RESET) begin
                r_gate_q <= 1'b1;
                r_clk    <= 1'b0;
                r_active <= 1'b0;
            end else begin
                r_gate_q <= w_gate_nxt;
                r_clk    <= r_raw & r_gate_q;
                r_active <= w_active_nxt;
            end
        end

        // Shadow (written any time) and active (loaded on w_copy) config.
        always_ff @(posedge CLOCK or posedge RESET) begin
            if (RESET) begin
                r_sh_half   <= DIV_W'(1'b1);
                r_sh_phase  <= {PHASE_W{1'b0}};
                r_act_half  <= DIV_W'(1'b1);
                r_act_phase <= {PHASE_W{1'b0}};
            end else begin
                if (w_sel) begin
                    r_sh_half  <= bus.cfg_half_div;
                    r_sh_phase <= bus.cfg_phase;
                end
                // Nonblocking: a write in the copy cycle waits for the next copy.
                if (w_copy) begin
                    r_act_half  <= r_sh_half;
                    r_act_phase <= r_sh_phase;
                end
            end
        end

        assign w_clk_v[gi]    = r_clk;
        assign w_active_v[gi] = r_active;

`ifdef CLOCK_DIV_GEN_EVT_EN
        logic r_pend, r_evt_cfg, r_evt_gate;

        // Pending-write tracking and event pulses.
        always_ff @(posedge CLOCK or posedge RESET) begin
            if (RESET) begin
                r_pend     <= 1'b0;
                r_evt_cfg  <= 1'b0;
                r_evt_gate <= 1'b0;
            end else begin
                if (w_sel)       r_pend <= 1'b1;
                else if (w_copy) r_pend <= 1'b0;
                else             r_pend <= r_pend;
                r_evt_cfg  <= w_copy & r_pend;
                r_evt_gate <= w_gate_nxt ^ r_gate_q;
            end
        end

        assign w_evt_cfg_v[gi]  = r_evt_cfg;
        assign w_evt_gate_v[gi] = r_evt_gate;
`else
        assign w_evt_cfg_v[gi]  = 1'b0;
        assign w_evt_gate_v[gi] = 1'b0;
`endif
    end

    assign bus.cfg_err      = r_cfg_err;
    assign bus.ch_clk       = w_clk_v;
    assign bus.ch_active    = w_active_v;
    assign bus.evt_cfg_done = w_evt_cfg_v;
    assign bus.evt_gate     = w_evt_gate_v;
endmodule

// File: tb/tb_clock_div_gen.sv
module tb_clock_div_gen;
`ifdef CLOCK_DIV_GEN_EVT_EN
    localparam bit EVT_ON = 1'b1;
`else
    localparam bit EVT_ON = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    sb_t  sbq[$];

    clock_div_gen_if #(.NUM_CH(4), .DIV_W(8), .PHASE_W(8)) bus ();
    clock_div_gen_if #(.NUM_CH(3), .DIV_W(8), .PHASE_W(8)) bus3 ();

    clock_div_gen #(.NUM_CH(4), .DIV_W(8), .PHASE_W(8)) dut (
        .CLOCK(clk), .RESET(rst), .bus(bus)
    );
    clock_div_gen #(.NUM_CH(3), .DIV_W(8), .PHASE_W(8)) dut3 (
        .CLOCK(clk), .RESET(rst), .bus(bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by 100us");
        $fatal(1, "stalled");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] e);
        sb_t it;
        it.tag = tag;
        it.exp = e;
        sbq.push_back(it);
    endtask

    task automatic check_val(input logic [31:0] obs);
        sb_t it;
        vectors++;
        if (sbq.size() == 0) begin
            miscompares++;
            $error("FAIL sb_underflow observed=%0h expected=<none>", obs);
        end else begin
            it = sbq.pop_front();
            assert (obs === it.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] half, input logic [7:0] ph);
        bus.cfg_wr       = 1'b1;
        bus.cfg_ch       = ch;
        bus.cfg_half_div = half;
        bus.cfg_phase    = ph;
        tick();
        bus.cfg_wr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.ch_active != 4'h0 && n < 40) begin
            tick();
            n++;
        end
        push(tag, 32'h0);
        check_val(32'(bus.ch_active));
    endtask

    function automatic logic [3:0] t5_exp(input int k);
        logic [3:0] v;
        v = 4'h0;
        for (int c = 0; c < 4; c++) v[c] = (k >= 1) && ((((k - 1) / (c + 1)) % 2) == 0);
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        bus.cfg_wr = 1'b0; bus.cfg_ch = 2'd0; bus.cfg_half_div = 8'd0; bus.cfg_phase = 8'd0;
        bus.ch_en = 4'h0; bus.gate_en = 4'hF;
        bus3.cfg_wr = 1'b0; bus3.cfg_ch = 2'd0; bus3.cfg_half_div = 8'd0; bus3.cfg_phase = 8'd0;
        bus3.ch_en = 3'b000; bus3.gate_en = 3'b111;

        // Reset values
        repeat (3) tick();
        push("rst_clk", 32'h0);  push("rst_active", 32'h0); push("rst_err", 32'h0);
        push("rst_evt_cfg", 32'h0); push("rst_evt_gate", 32'h0);
        check_val(32'(bus.ch_clk)); check_val(32'(bus.ch_active)); check_val(32'(bus.cfg_err));
        check_val(32'(bus.evt_cfg_done)); check_val(32'(bus.evt_gate));
        rst = 1'b0;
        tick();
        push("post_rst_clk", 32'h0); push("post_rst_active", 32'h0);
        check_val(32'(bus.ch_clk)); check_val(32'(bus.ch_active));

        // 1: half=3 phase=2, first rise 3 edges after enable, then 3/3
        wr(2'd0, 8'd3, 8'd2);
        bus.ch_en[0] = 1'b1;
        push("t1_active0", 32'h1);
        for (int k = 0; k < 15; k++)
            push($sformatf("t1_clk0_k%0d", k), 32'((k >= 3) && ((((k - 3) / 3) % 2) == 0)));
        tick();
        check_val(32'(bus.ch_active[0]));
        for (int k = 0; k < 15; k++) begin
            check_val(32'(bus.ch_clk[0]));
            tick();
        end
        bus.ch_en[0] = 1'b0;
        wait_idle("t1_idle");

        // 2: half=2 running, write half=5 during a high half
        wr(2'd0, 8'd2, 8'd0);
        bus.ch_en[0] = 1'b1;
        for (int k = 0; k < 25; k++) begin
            logic e;
            if (k < 7)       e = ((k % 4) == 1) || ((k % 4) == 2);
            else if (k < 12) e = 1'b0;
            else             e = (((k - 12) / 5) % 2) == 0;
            push($sformatf("t2_clk0_k%0d", k), 32'(e));
            push($sformatf("t2_evtcfg0_k%0d", k), 32'(EVT_ON && (k == 0 || k == 6)));
        end
        tick();
        for (int k = 0; k < 25; k++) begin
            check_val(32'(bus.ch_clk[0]));
            check_val(32'(bus.evt_cfg_done[0]));
            if (k == 4) begin
                bus.cfg_wr = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_half_div = 8'd5; bus.cfg_phase = 8'd0;
            end else begin
                bus.cfg_wr = 1'b0;
            end
            tick();
        end

        // 3: ch1 half=4, gate closed then reopened during high halves
        wr(2'd1, 8'd4, 8'd0);
        bus.ch_en[1] = 1'b1;
        for (int k = 0; k < 37; k++) begin
            push($sformatf("t3_clk1_k%0d", k),
                 32'((k >= 1 && k <= 4) || (k >= 9 && k <= 12) || (k >= 25 && k <= 28) || (k >= 33 && k <= 36)));
            push($sformatf("t3_evtgate1_k%0d", k), 32'(EVT_ON && (k == 13 || k == 21)));
        end
        tick();
        for (int k = 0; k < 37; k++) begin
            check_val(32'(bus.ch_clk[1]));
            check_val(32'(bus.evt_gate[1]));
            if (k == 8)  bus.gate_en[1] = 1'b0;
            if (k == 17) bus.gate_en[1] = 1'b1;
            tick();
        end

        // 4: illegal writes rejected, shadow untouched
        bus.cfg_wr = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_half_div = 8'd0; bus.cfg_phase = 8'd7;
        bus3.cfg_wr = 1'b1; bus3.cfg_ch = 2'd3; bus3.cfg_half_div = 8'd2;
        push("t4_err_half0", 32'h1); push("t4_err_ch3", 32'h1);
        tick();
        check_val(32'(bus.cfg_err)); check_val(32'(bus3.cfg_err));
        bus.cfg_wr = 1'b0;
        bus3.cfg_ch = 2'd2;
        push("t4_err_clear", 32'h0); push("t4_err_ch2_ok", 32'h0);
        tick();
        check_val(32'(bus.cfg_err)); check_val(32'(bus3.cfg_err));
        bus3.cfg_wr = 1'b0;
        bus.ch_en[0] = 1'b0;
        wait_idle_ch0: begin
            int n;
            n = 0;
            while (bus.ch_active[0] && n < 40) begin tick(); n++; end
            push("t4_idle0", 32'h0);
            check_val(32'(bus.ch_active[0]));
        end
        bus.ch_en[0] = 1'b1;
        for (int k = 0; k < 11; k++)
            push($sformatf("t4_clk0_k%0d", k), 32'(k >= 1 && k <= 5));
        tick();
        for (int k = 0; k < 11; k++) begin
            check_val(32'(bus.ch_clk[0]));
            tick();
        end

        // 5: four channels half=1..4 started together
        bus.ch_en = 4'h0;
        wait_idle("t5_idle");
        wr(2'd0, 8'd1, 8'd0);
        wr(2'd1, 8'd2, 8'd0);
        wr(2'd2, 8'd3, 8'd0);
        wr(2'd3, 8'd4, 8'd0);
        bus.ch_en = 4'hF;
        for (int k = 0; k < 50; k++) push($sformatf("t5_clk_k%0d", k), 32'(t5_exp(k)));
        tick();
        for (int k = 0; k < 50; k++) begin
            check_val(32'(bus.ch_clk));
            if (k < 49) tick();
        end

        // 6: asynchronous reset while all clocks are high
        #2;
        rst = 1'b1;
        push("t6_rst_clk", 32'h0); push("t6_rst_active", 32'h0);
        #1;
        check_val(32'(bus.ch_clk)); check_val(32'(bus.ch_active));
        tick();
        bus.ch_en = 4'h0;
        rst = 1'b0;
        tick();
        bus.ch_en[3] = 1'b1;
        for (int k = 0; k < 9; k++) push($sformatf("t6_clk_k%0d", k), ((k % 2) == 1) ? 32'h8 : 32'h0);
        tick();
        for (int k = 0; k < 9; k++) begin
            check_val(32'(bus.ch_clk));
            tick();
        end

        vectors++;
        assert (sbq.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
